kmeans_assign_engine: RTL and testbench
=======================================

Name: kmeans_assign_engine

Overview:
- Parametrised K-means assignment/accumulation engine; successor to the fixed 16-cluster, 24-bit RGB `bengine`.
- Streams pixels, finds the nearest enabled mean, and accumulates per-cluster channel sums and member counts.
- Generalised in cluster count, channel count and channel width; adds a valid/ready handshake, a pipelined argmin, a frame state machine, saturation and a per-pixel label output.
- Sits between the pixel reader and the mean-update divider.

Parameters:
- K, 16, number of clusters (2..32)
- CH, 3, channels per pixel
- CW, 8, bits per channel
- ACCW, 32, bits per accumulator channel
- CNTW, 16, bits per cluster counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse; snapshots means/mask, clears sums, begins frame
- mean_in  in  K*CH*CW  cluster means; cluster k at bits [(k+1)*CH*CW-1 : k*CH*CW]; channel c at LSB-first CW slices
- enabled  in  K  per-cluster participation mask
- valid_in  in  1  pixel_in valid
- ready_out  out  1  engine accepts pixel this cycle
- pixel_in  in  CH*CW  pixel, channel 0 in LSBs
- end_of_image  in  1  qualifies the accepted pixel as last of frame
- label_out  out  clog2(K)  nearest cluster of the pipelined pixel
- label_valid  out  1  label_out valid
- accumulator  out  K*CH*ACCW  per-cluster channel sums, same packing as mean_in
- counters  out  K*CNTW  per-cluster member counts
- busy  out  1  state is RUN or DRAIN
- done  out  1  one-cycle frame-complete pulse
- overflow  out  1  sticky saturation flag

Behaviour:
- Reset (async, reset=0): state IDLE. All outputs 0, including accumulator, counters, label_out and overflow. Pipeline valids cleared. Reset mid-frame abandons the frame; no done is generated.
- States:
  - IDLE: wait for start.
  - RUN: ready_out=1.
  - DRAIN: ready_out=0, wait for the pipeline to empty.
  - DONE: results held.
- Transitions:
  - IDLE/DONE --start--> RUN: same edge registers mean_in/enabled, zeroes accumulator/counters/overflow.
  - RUN: accepted pixel with end_of_image=1 --> DRAIN.
  - DRAIN: pipeline empty --> DONE; done=1 for exactly the first cycle in DONE.
  - start in RUN/DRAIN is ignored.
  - end_of_image without valid_in is ignored.
- Accept = valid_in & ready_out. Means and mask are stable for the whole frame (snapshot only).
- Pipeline (accept edge E0):
  - E0: per-cluster distance registered. Default metric is L1, sum of |p_c - m_c|, width CW+clog2(CH).
  - E1: argmin registered; label_out/label_valid high from E1 to E2 (valid one cycle per accepted pixel).
  - E2: accumulator[label][c] += p_c, counters[label] += 1.
  - done goes high after E3 for the last pixel, i.e. 3 cycles after its acceptance edge, high one cycle.
- Argmin:
  - Disabled clusters are excluded.
  - Ties go to the lowest index.
  - If no cluster is enabled: label_out=0, label_valid=0, and nothing is accumulated (pixel consumed, frame still completes).
- Saturation:
  - Counters and accumulator channels clamp at all-ones and never wrap.
  - Any clamp sets overflow, which stays set until the next start or reset.
- Back-to-back pixels every cycle are supported; throughput is 1 pixel/clock.
- valid_in low creates bubbles; the pipeline advances regardless.

Optional Feature:
- Macro: KMEANS_SQDIST_EN.
- Defined: metric is squared Euclidean, sum of (p_c - m_c)^2, distance width 2*CW+clog2(CH). Latency is unchanged.
- Undefined: L1 metric as above. Argmin, tie and mask rules are identical in both cases.

Test Plan:
- Defaults; means 0,16,...,224,255 per channel (all channels equal); all enabled; start; single pixel 0x101010 with end_of_image → label_out=1 one cycle at E1, counters[1]=1, accumulator[1] channels=16, done pulse 3 cycles after accept, all other counters 0.
- Tie: pixel 0x080808 → label 0. Same pixel with enabled[0]=0 → label 1.
- Stream 4 pixels back-to-back (0x000000, 0xFFFFFF, 0x7F7F7F, 0x8C8C8C, last tagged) → labels 0,15,8,9 on consecutive cycles; counters[0]=counters[15]=counters[8]=counters[9]=1; ready_out low from the cycle after last accept until the next start.
- CNTW=4: 17 pixels of 0x000000 → counters[0]=15, overflow=1. New start → counters 0, overflow 0.
- Reset asserted while 2 pixels are in the pipeline → all outputs 0 immediately; no done; subsequent start+frame behaves normally.
- enabled=0 for all clusters: 3 pixels + end → no label_valid, counters all 0, done still pulses.

Source files
------------

// File: rtl/kmeans_assign_engine.sv
// kmeans_assign_engine: streaming K-means assignment and accumulation engine.
// Each accepted pixel is compared against a frame-wide snapshot of the cluster
// means. The nearest enabled cluster is chosen, and the pixel's channels are
// added into that cluster's saturating sums and member count.
// Pipeline: distance (E0) -> argmin/label (E1) -> accumulate (E2) -> done (E3).
// Optional build macro KMEANS_SQDIST_EN switches the metric from L1 to squared
// Euclidean. Latency is the same for both metrics.
module kmeans_assign_engine #(
  parameter int K    = 16,
  parameter int CH   = 3,
  parameter int CW   = 8,
  parameter int ACCW = 32,
  parameter int CNTW = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [K*CH*CW-1:0]      mean_in,
  input  logic [K-1:0]            enabled,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic [CH*CW-1:0]        pixel_in,
  input  logic                    end_of_image,
  output logic [$clog2(K)-1:0]    label_out,
  output logic                    label_valid,
  output logic [K*CH*ACCW-1:0]    accumulator,
  output logic [K*CNTW-1:0]       counters,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  localparam int LW = $clog2(K);
`ifdef KMEANS_SQDIST_EN
  localparam int DW = 2*CW + $clog2(CH);
`else
  localparam int DW = CW + $clog2(CH);
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state;

  logic [K*CH*CW-1:0] mean_q;
  logic [K-1:0]       en_q;

  logic               accept;
  logic               start_go;

  logic [DW-1:0]      dist_next [K];
  logic [DW-1:0]      dist_q    [K];
  logic               s0_valid;
  logic [CH*CW-1:0]   s0_pixel;

  logic [LW-1:0]      best_idx;
  logic [DW-1:0]      best_d;
  logic               found;

  logic               s1_valid;
  logic               s1_hit;
  logic [CH*CW-1:0]   s1_pixel;

  logic [ACCW:0]      acc_sum [CH];
  logic [CNTW:0]      cnt_sum;
  logic               any_clamp;

  assign accept   = valid_in & ready_out;
  assign start_go = start & ((state == S_IDLE) || (state == S_DONE));

  // Frame control. Start is honoured only from IDLE or DONE. The last accepted
  // pixel moves the engine to DRAIN, and DONE is entered once both pipeline
  // stages are empty, so done lands three edges after the last accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ready_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_RUN;
            ready_out <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_RUN: begin
          if (accept && end_of_image) begin
            state     <= S_DRAIN;
            ready_out <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!s0_valid && !s1_valid) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          ready_out <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Means and participation mask are captured once per frame so they cannot
  // shift while pixels are in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mean_q <= '0;
      en_q   <= '0;
    end else if (start_go) begin
      mean_q <= mean_in;
      en_q   <= enabled;
    end
  end

  // Per-cluster distance from the incoming pixel to each snapshotted mean.
  always_comb begin
    logic [CW-1:0]   p;
    logic [CW-1:0]   m;
    logic [CW-1:0]   ad;
    logic [2*CW-1:0] ad_ext;
    logic [2*CW-1:0] sq;
    for (int k = 0; k < K; k++) begin
      dist_next[k] = '0;
      for (int c = 0; c < CH; c++) begin
        p      = pixel_in[c*CW +: CW];
        m      = mean_q[(k*CH+c)*CW +: CW];
        ad     = (p >= m) ? (p - m) : (m - p);
        ad_ext = (2*CW)'(ad);
        sq     = ad_ext * ad_ext;
`ifdef KMEANS_SQDIST_EN
        dist_next[k] = dist_next[k] + DW'(sq);
`else
        dist_next[k] = dist_next[k] + DW'(ad);
`endif
      end
    end
  end

  // Stage E0: register the distances and the pixel they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_valid <= 1'b0;
      s0_pixel <= '0;
      for (int k = 0; k < K; k++) dist_q[k] <= '0;
    end else begin
      s0_valid <= accept;
      if (accept) begin
        s0_pixel <= pixel_in;
        for (int k = 0; k < K; k++) dist_q[k] <= dist_next[k];
      end
    end
  end

  // Argmin over enabled clusters. A strict less-than keeps the lowest index
  // on ties. With no enabled cluster, found stays low and the index stays 0.
  always_comb begin
    best_idx = '0;
    best_d   = '0;
    found    = 1'b0;
    for (int k = 0; k < K; k++) begin
      if (en_q[k] && (!found || (dist_q[k] < best_d))) begin
        found    = 1'b1;
        best_d   = dist_q[k];
        best_idx = LW'(k);
      end
    end
  end

  // Stage E1: register the winning label. s1_valid tracks pipeline occupancy
  // even when no cluster wins, so the frame still drains and completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid    <= 1'b0;
      s1_hit      <= 1'b0;
      s1_pixel    <= '0;
      label_out   <= '0;
      label_valid <= 1'b0;
    end else begin
      s1_valid    <= s0_valid;
      label_valid <= s0_valid & found;
      if (s0_valid) begin
        s1_hit    <= found;
        s1_pixel  <= s0_pixel;
        label_out <= best_idx;
      end
    end
  end

  // Candidate sums for the labelled cluster, one bit wider to expose carry-out.
  always_comb begin
    int lbl;
    lbl       = int'(label_out);
    any_clamp = 1'b0;
    for (int c = 0; c < CH; c++) begin
      acc_sum[c] = {1'b0, accumulator[(lbl*CH+c)*ACCW +: ACCW]}
                 + (ACCW+1)'(s1_pixel[c*CW +: CW]);
      if (acc_sum[c][ACCW]) any_clamp = 1'b1;
    end
    cnt_sum = {1'b0, counters[lbl*CNTW +: CNTW]} + (CNTW+1)'(1);
    if (cnt_sum[CNTW]) any_clamp = 1'b1;
  end

  // Stage E2: saturating accumulation into the winning cluster. A new frame
  // clears all sums, counts and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accumulator <= '0;
      counters    <= '0;
      overflow    <= 1'b0;
    end else if (start_go) begin
      accumulator <= '0;
      counters    <= '0;
      overflow    <= 1'b0;
    end else if (s1_valid && s1_hit) begin
      for (int c = 0; c < CH; c++) begin
        if (acc_sum[c][ACCW])
          accumulator[(int'(label_out)*CH+c)*ACCW +: ACCW] <= '1;
        else
          accumulator[(int'(label_out)*CH+c)*ACCW +: ACCW] <= acc_sum[c][ACCW-1:0];
      end
      if (cnt_sum[CNTW])
        counters[int'(label_out)*CNTW +: CNTW] <= '1;
      else
        counters[int'(label_out)*CNTW +: CNTW] <= cnt_sum[CNTW-1:0];
      if (any_clamp) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kmeans_assign_engine.sv
// tb_kmeans_assign_engine: directed self-checking bench for kmeans_assign_engine.
// Uses a default-width instance plus a second instance with 4-bit counters,
// so counter saturation is reachable with only a few pixels.
module tb_kmeans_assign_engine;
  localparam int K      = 16;
  localparam int CH     = 3;
  localparam int CW     = 8;
  localparam int ACCW   = 32;
  localparam int CNTW   = 16;
  localparam int CNTW_S = 4;

  logic clk = 1'b0;
  logic reset;
  logic start, valid_in, end_of_image;
  logic [K*CH*CW-1:0]   mean_in;
  logic [K-1:0]         enabled;
  logic [CH*CW-1:0]     pixel_in;
  logic                 ready_out, label_valid, busy, done, overflow;
  logic [$clog2(K)-1:0] label_out;
  logic [K*CH*ACCW-1:0] accumulator;
  logic [K*CNTW-1:0]    counters;

  logic start_s, valid_s, eoi_s;
  logic [K-1:0]         enabled_s;
  logic [CH*CW-1:0]     pixel_s;
  logic                 ready_s, label_valid_s, busy_s, done_s, overflow_s;
  logic [$clog2(K)-1:0] label_s;
  logic [K*CH*ACCW-1:0] accumulator_s;
  logic [K*CNTW_S-1:0]  counters_s;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int done_count = 0;
  int label_q[$];
  int label_cyc[$];

  kmeans_assign_engine #(.K(K), .CH(CH), .CW(CW), .ACCW(ACCW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .start(start), .mean_in(mean_in), .enabled(enabled),
    .valid_in(valid_in), .ready_out(ready_out), .pixel_in(pixel_in),
    .end_of_image(end_of_image), .label_out(label_out), .label_valid(label_valid),
    .accumulator(accumulator), .counters(counters), .busy(busy), .done(done),
    .overflow(overflow)
  );

  kmeans_assign_engine #(.K(K), .CH(CH), .CW(CW), .ACCW(ACCW), .CNTW(CNTW_S)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .mean_in(mean_in), .enabled(enabled_s),
    .valid_in(valid_s), .ready_out(ready_s), .pixel_in(pixel_s),
    .end_of_image(eoi_s), .label_out(label_s), .label_valid(label_valid_s),
    .accumulator(accumulator_s), .counters(counters_s), .busy(busy_s), .done(done_s),
    .overflow(overflow_s)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Record every label and done pulse of the main instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (label_valid) begin
      label_q.push_back(int'(label_out));
      label_cyc.push_back(cycle);
    end
    if (done) done_count++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CNTW-1:0] cnt(input int k);
    return counters[k*CNTW +: CNTW];
  endfunction

  function automatic logic [ACCW-1:0] acc(input int k, input int c);
    return accumulator[(k*CH+c)*ACCW +: ACCW];
  endfunction

  task automatic applyStimulus_start(input logic [K-1:0] en);
    enabled = en;
    start = 1'b1;
    tick();
    start = 1'b0;
    label_q.delete();
    label_cyc.delete();
    done_count = 0;
  endtask

  task automatic applyStimulus(input logic [CH*CW-1:0] pix, input logic last);
    valid_in = 1'b1;
    pixel_in = pix;
    end_of_image = last;
    tick();
    valid_in = 1'b0;
    end_of_image = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    checkOutput(tag, done, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation timed out");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b0;
    start = 0; valid_in = 0; end_of_image = 0; pixel_in = '0; enabled = '1;
    start_s = 0; valid_s = 0; eoi_s = 0; pixel_s = '0; enabled_s = '1;
    for (int k = 0; k < K; k++)
      for (int c = 0; c < CH; c++)
        mean_in[(k*CH+c)*CW +: CW] = (k == 15) ? 8'd255 : 8'(k*16);
    #12;
    checkOutput("reset_ready", ready_out, 0);
    checkOutput("reset_busy_done", {busy, done, overflow, label_valid}, 0);
    checkOutput("reset_counters", counters == '0, 1);
    checkOutput("reset_acc", accumulator == '0, 1);
    reset = 1'b1;
    tick();

    // Single pixel: exact latency of label, accumulate and done.
    applyStimulus_start('1);
    checkOutput("run_ready", ready_out, 1);
    checkOutput("run_busy", busy, 1);
    applyStimulus(24'h101010, 1'b1);
    checkOutput("drain_ready", ready_out, 0);
    checkOutput("e0_label_valid", label_valid, 0);
    tick();
    checkOutput("e1_label_valid", label_valid, 1);
    checkOutput("e1_label", label_out, 1);
    tick();
    checkOutput("e2_label_valid", label_valid, 0);
    checkOutput("e2_done", done, 0);
    checkOutput("e2_cnt1", cnt(1), 1);
    tick();
    checkOutput("e3_done", done, 1);
    tick();
    checkOutput("after_done", {done, busy}, 0);
    for (int c = 0; c < CH; c++) checkOutput($sformatf("acc1_c%0d", c), acc(1, c), 16);
    checkOutput("other_cnt", counters == (256'(1) << CNTW), 1);
    checkOutput("done_count_single", done_count, 1);

    // Tie breaks to lowest index; masking cluster 0 moves it to cluster 1.
    applyStimulus_start('1);
    applyStimulus(24'h080808, 1'b1);
    wait_done("tie_done");
    checkOutput("tie_count", label_q.size(), 1);
    checkOutput("tie_label", label_q[0], 0);
    applyStimulus_start(16'hFFFE);
    applyStimulus(24'h080808, 1'b1);
    wait_done("mask_done");
    checkOutput("mask_label", label_q[0], 1);
    checkOutput("mask_cnt0", cnt(0), 0);
    checkOutput("mask_cnt1", cnt(1), 1);

    // Back-to-back stream.
    applyStimulus_start('1);
    applyStimulus(24'h000000, 1'b0);
    applyStimulus(24'hFFFFFF, 1'b0);
    applyStimulus(24'h7F7F7F, 1'b0);
    applyStimulus(24'h8C8C8C, 1'b1);
    checkOutput("stream_ready_low", ready_out, 0);
    wait_done("stream_done");
    checkOutput("stream_count", label_q.size(), 4);
    if (label_q.size() == 4) begin
      checkOutput("stream_l0", label_q[0], 0);
      checkOutput("stream_l1", label_q[1], 15);
      checkOutput("stream_l2", label_q[2], 8);
      checkOutput("stream_l3", label_q[3], 9);
      for (int i = 1; i < 4; i++)
        checkOutput($sformatf("stream_cyc%0d", i), label_cyc[i] - label_cyc[0], i);
    end
    checkOutput("stream_cnt0", cnt(0), 1);
    checkOutput("stream_cnt15", cnt(15), 1);
    checkOutput("stream_cnt8", cnt(8), 1);
    checkOutput("stream_cnt9", cnt(9), 1);
    checkOutput("stream_acc15", acc(15, 2), 255);
    checkOutput("stream_acc9", acc(9, 0), 140);
    tick();
    checkOutput("done_ready_low", ready_out, 0);

    // Reset with pixels in flight.
    applyStimulus_start('1);
    checkOutput("rst_start_ready", ready_out, 1);
    applyStimulus(24'h000000, 1'b0);
    applyStimulus(24'hFFFFFF, 1'b0);
    applyStimulus(24'h101010, 1'b0);
    checkOutput("pre_rst_cnt0", cnt(0), 1);
    reset = 1'b0;
    #1;
    checkOutput("rst_counters", counters == '0, 1);
    checkOutput("rst_acc", accumulator == '0, 1);
    checkOutput("rst_flags", {ready_out, busy, done, label_valid, overflow}, 0);
    checkOutput("rst_label", label_out, 0);
    done_count = 0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick(); tick(); tick();
    checkOutput("rst_no_done", done_count, 0);
    checkOutput("rst_idle_ready", ready_out, 0);
    applyStimulus_start('1);
    applyStimulus(24'hFFFFFF, 1'b1);
    wait_done("post_rst_done");
    checkOutput("post_rst_cnt15", cnt(15), 1);
    checkOutput("post_rst_total", counters == (256'(1) << (15*CNTW)), 1);

    // No cluster enabled.
    applyStimulus_start('0);
    applyStimulus(24'h101010, 1'b0);
    applyStimulus(24'h202020, 1'b0);
    applyStimulus(24'h303030, 1'b1);
    wait_done("none_done");
    checkOutput("none_labels", label_q.size(), 0);
    checkOutput("none_counters", counters == '0, 1);
    checkOutput("none_done_count", done_count, 1);

    // Counter saturation on the narrow instance.
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int i = 0; i < 17; i++) begin
      valid_s = 1'b1;
      pixel_s = 24'h000000;
      eoi_s = (i == 16);
      tick();
    end
    valid_s = 1'b0;
    eoi_s = 1'b0;
    begin
      int n = 0;
      while (!done_s && n < 20) begin
        tick();
        n++;
      end
      checkOutput("sat_done", done_s, 1);
    end
    checkOutput("sat_cnt0", counters_s[0 +: CNTW_S], 15);
    checkOutput("sat_overflow", overflow_s, 1);
    checkOutput("sat_others", counters_s[K*CNTW_S-1:CNTW_S] == '0, 1);
    tick();
    checkOutput("sat_overflow_hold", overflow_s, 1);
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    checkOutput("sat_clear_cnt", counters_s == '0, 1);
    checkOutput("sat_clear_ovf", overflow_s, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
